// File: rtl/incdec_sched.sv
// incdec_sched: shares one 8-bit inc8/dec8 pair among N_REQ requesters that
// need 16-bit +1/-1. Each op runs a low-byte pass, then a high-byte pass
// only when the low byte carries/borrows.
// Optional feature: define INCDEC_SCHED_RR_EN for round-robin arbitration;
// the default build uses fixed priority (lowest index wins).
//
// Handshake: req[i] is a level held until ack[i]; ack[i] is a one-cycle pulse
// in the DONE state with result/wrap valid in that same cycle. Counting the
// cycle in which IDLE samples req as cycle 1, ack is high in cycle 3 (no
// carry/borrow) or cycle 4 (high-byte pass taken).

// 8-bit incrementer with carry out
module inc8 (
   input  logic [7:0] a,
   output logic [7:0] y,
   output logic       cout
);
   assign {cout, y} = {1'b0, a} + 9'd1;
endmodule

// 8-bit decrementer with borrow out
module dec8 (
   input  logic [7:0] a,
   output logic [7:0] y,
   output logic       bout
);
   assign y    = a - 8'd1;
   assign bout = (a == 8'd0);
endmodule

module incdec_sched #(
   parameter int N_REQ = 3,
   parameter int IDW   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     op,
   input  logic [16*N_REQ-1:0]  operand,
   output logic [N_REQ-1:0]     ack,
   output logic [15:0]          result,
   output logic                 wrap,
   output logic [IDW-1:0]       gnt_id,
   output logic                 busy
);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t          state;
   logic [IDW-1:0]  gnt_q;
   logic            op_q;
   logic [15:0]     opnd_q;
   logic [7:0]      lo_q;

   logic            win_vld;
   logic [IDW-1:0]  win_id;
   logic            win_op;
   logic [15:0]     win_opnd;
   logic [N_REQ-1:0] gnt_hot;

   logic [7:0]      byte_in;
   logic [7:0]      inc_y, dec_y, unit_y;
   logic            inc_c, dec_b, unit_c;

`ifdef INCDEC_SCHED_RR_EN
   logic [IDW-1:0]  rr_ptr;
`endif

   // The shared unit sees the low byte in LO and the high byte in HI.
   assign byte_in = (state == S_HI) ? opnd_q[15:8] : opnd_q[7:0];

   inc8 u_inc8 (.a(byte_in), .y(inc_y), .cout(inc_c));
   dec8 u_dec8 (.a(byte_in), .y(dec_y), .bout(dec_b));

   assign unit_y = op_q ? dec_y : inc_y;
   assign unit_c = op_q ? dec_b : inc_c;

   // Pick the winning requester among the asserted requests.
   always_comb begin
      int j;
      j       = 0;
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef INCDEC_SCHED_RR_EN
         j = int'(rr_ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
`else
         j = k;
`endif
         if (!win_vld && req[j]) begin
            win_vld = 1'b1;
            win_id  = IDW'(j);
         end
      end
   end

   // Route the winner's op/operand and form the one-hot ack of the grant.
   always_comb begin
      win_op   = 1'b0;
      win_opnd = '0;
      gnt_hot  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (IDW'(k) == win_id) begin
            win_op   = op[k];
            win_opnd = operand[16*k +: 16];
         end
         gnt_hot[k] = (IDW'(k) == gnt_q);
      end
   end

   // Sequencer: grant, low-byte pass, optional high-byte pass, ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         gnt_q  <= '0;
         op_q   <= 1'b0;
         opnd_q <= '0;
         lo_q   <= '0;
         ack    <= '0;
         result <= '0;
         wrap   <= 1'b0;
`ifdef INCDEC_SCHED_RR_EN
         rr_ptr <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               ack <= '0;
               if (win_vld) begin
                  gnt_q  <= win_id;
                  op_q   <= win_op;
                  opnd_q <= win_opnd;
                  state  <= S_LO;
`ifdef INCDEC_SCHED_RR_EN
                  rr_ptr <= (win_id == IDW'(N_REQ-1)) ? '0 : win_id + IDW'(1);
`endif
               end
            end
            S_LO: begin
               if (unit_c) begin
                  lo_q  <= unit_y;
                  state <= S_HI;
               end else begin
                  // No carry/borrow: the high byte passes through unchanged.
                  result <= {opnd_q[15:8], unit_y};
                  wrap   <= 1'b0;
                  ack    <= gnt_hot;
                  state  <= S_DONE;
               end
            end
            S_HI: begin
               result <= {unit_y, lo_q};
               wrap   <= unit_c;
               ack    <= gnt_hot;
               state  <= S_DONE;
            end
            default: begin
               ack   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt_id = gnt_q;
   assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_incdec_sched.sv
// Directed testbench for incdec_sched (N_REQ=3). Works in either the default
// fixed-priority build or with INCDEC_SCHED_RR_EN defined.
module tb_incdec_sched;

   localparam int N_REQ = 3;
   localparam int IDW   = 2;

   logic                clk;
   logic                rst_n;
   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    op;
   logic [16*N_REQ-1:0] operand;
   logic [N_REQ-1:0]    ack;
   logic [15:0]         result;
   logic                wrap;
   logic [IDW-1:0]      gnt_id;
   logic                busy;

   int n_chk;
   int n_bad;

   incdec_sched #(.N_REQ(N_REQ), .IDW(IDW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .op      (op),
      .operand (operand),
      .ack     (ack),
      .result  (result),
      .wrap    (wrap),
      .gnt_id  (gnt_id),
      .busy    (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (at negedges) until any ack is seen; returns cycles waited.
   task automatic wait_ack(input string tag, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (ack == '0 && cyc < 20);
      if (ack == '0) check_eq({tag, "_timeout"}, 32'(cyc), 32'd0);
   endtask

   // Issue one request and check latency, ack, result, wrap, gnt_id.
   // lat counts the sampling cycle as cycle 1.
   task automatic do_op(input string tag, input int id, input logic o,
                        input logic [15:0] opnd, input logic [15:0] exp_res,
                        input logic exp_wrap, input int lat);
      int cyc;
      @(negedge clk);
      operand[16*id +: 16] = opnd;
      op[id]  = o;
      req[id] = 1'b1;
      wait_ack(tag, cyc);
      check_eq({tag, "_lat"},    32'(cyc + 1), 32'(lat));
      check_eq({tag, "_ack"},    32'(ack), 32'(1 << id));
      check_eq({tag, "_res"},    32'(result), 32'(exp_res));
      check_eq({tag, "_wrap"},   32'(wrap), 32'(exp_wrap));
      check_eq({tag, "_gnt"},    32'(gnt_id), 32'(id));
      req[id] = 1'b0;
      @(negedge clk);
      check_eq({tag, "_ackdrop"}, 32'(ack), 32'd0);
      check_eq({tag, "_idle"},    32'(busy), 32'd0);
      check_eq({tag, "_hold"},    32'(result), 32'(exp_res));
   endtask

   logic [1:0] exp_order [4];

   initial begin
      int cyc;
      n_chk   = 0;
      n_bad   = 0;
      req     = '0;
      op      = '0;
      operand = '0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_ack",  32'(ack), 32'd0);
      check_eq("rst_res",  32'(result), 32'd0);
      check_eq("rst_wrap", 32'(wrap), 32'd0);
      check_eq("rst_gnt",  32'(gnt_id), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1..3: basic arithmetic, carry/borrow paths, wrap cases
      do_op("inc_nc",   0, 1'b0, 16'h0012, 16'h0013, 1'b0, 3);
      do_op("inc_c",    1, 1'b0, 16'h00FF, 16'h0100, 1'b0, 4);
      do_op("dec_wrap", 2, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 4);
      do_op("inc_wrap", 0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 4);
      do_op("dec_b",    1, 1'b1, 16'h1200, 16'h11FF, 1'b0, 4);
      do_op("dec_nc",   2, 1'b1, 16'hAB05, 16'hAB04, 1'b0, 3);

      // 4: all three requesting continuously
`ifdef INCDEC_SCHED_RR_EN
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
      exp_order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
      @(negedge clk);
      operand = {16'h0030, 16'h0020, 16'h0010};
      op      = 3'b000;
      req     = 3'b111;
      for (int n = 0; n < 4; n++) begin
         wait_ack("arb", cyc);
         check_eq($sformatf("arb%0d_ack", n), 32'(ack), 32'(1 << exp_order[n]));
         check_eq($sformatf("arb%0d_res", n), 32'(result),
                  32'(16'h0011 + 16'h0010 * 16'(exp_order[n])));
         @(negedge clk);
      end
      req = '0;
      repeat (6) @(negedge clk);
      check_eq("arb_idle", 32'(busy), 32'd0);

      // 5: operand changes after grant are ignored
      @(negedge clk);
      operand[15:0] = 16'h1234;
      op[0]  = 1'b0;
      req[0] = 1'b1;
      @(negedge clk);
      check_eq("late_busy", 32'(busy), 32'd1);
      operand[15:0] = 16'h5555;
      wait_ack("late", cyc);
      check_eq("late_res", 32'(result), 32'h1235);
      check_eq("late_ack", 32'(ack), 32'd1);
      req[0] = 1'b0;
      repeat (3) @(negedge clk);

      // 6: reset during HI aborts the op with no ack
      operand[31:16] = 16'h00FF;
      op[1]  = 1'b0;
      req[1] = 1'b1;
      @(negedge clk);              // LO
      @(negedge clk);              // HI
      check_eq("abort_busy_hi", 32'(busy), 32'd1);
      check_eq("abort_gnt_hi",  32'(gnt_id), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("abort_ack",  32'(ack), 32'd0);
      check_eq("abort_res",  32'(result), 32'd0);
      check_eq("abort_wrap", 32'(wrap), 32'd0);
      check_eq("abort_gnt",  32'(gnt_id), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      req[1] = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("abort_noack", 32'(ack), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("post_rst_noack", 32'(ack), 32'd0);
      do_op("post_rst", 2, 1'b0, 16'h0041, 16'h0042, 1'b0, 3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1);
   end

endmodule
